// File: rtl/mt_pkg.sv
// Shared types and defaults for the MT stream buffer: fetch FSM states,
// FIFO/settle defaults and the sample payload handed from range reduction to the FIFO.
package mt_pkg;

    localparam int unsigned DEPTH_DEF  = 8;
    localparam int unsigned SETTLE_DEF = 2;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REJ_W      = 16;

    typedef enum logic [1:0] {
        ST_WAIT_GEN = 2'd0,
        ST_SETTLE   = 2'd1,
        ST_FETCH    = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic              accept;
        logic [DATA_W-1:0] value;
    } sample_t;

endpackage

// File: rtl/mt_fifo.sv
// Single-clock DEPTH x DW FIFO with a registered head word: a push into an
// empty FIFO is visible on rdata_o/valid_o one cycle later.
module mt_fifo
    import mt_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned DW    = DATA_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [DW-1:0]          wdata_i,
    input  logic                   pop_i,
    output logic [DW-1:0]          rdata_o,
    output logic                   valid_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [LW-1:0] lvl_q, lvl_d;
    logic [DW-1:0] head_q, head_d;
    logic          valid_q, valid_d;
    logic          wr_en;
    logic          rd_en;

    assign wr_en = push_i && (lvl_q != FULL_LVL);
    assign rd_en = pop_i && (lvl_q != '0);

    // Head tracks the entry at the post-update read pointer; bypass the write
    // data when that entry is the one being written this cycle.
    always_comb begin
        wptr_d  = wptr_q + AW'(wr_en);
        rptr_d  = rptr_q + AW'(rd_en);
        lvl_d   = lvl_q + LW'(wr_en) - LW'(rd_en);
        valid_d = (lvl_d != '0);
        head_d  = head_q;
        if (lvl_d != '0) begin
            if ((lvl_q - LW'(rd_en)) == '0) begin
                head_d = wdata_i;
            end else begin
                head_d = mem_q[rptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            lvl_q   <= '0;
            head_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            lvl_q   <= lvl_d;
            head_q  <= head_d;
            valid_q <= valid_d;
        end
    end

    assign rdata_o = head_q;
    assign valid_o = valid_q;
    assign level_o = lvl_q;

endmodule

// File: rtl/mt_stream_buffer.sv
// Paces a Mersenne-Twister style generator (settle gap between advances),
// range-reduces each word by mask-and-reject and buffers accepted words in a FIFO.
module mt_stream_buffer
    import mt_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned SETTLE = SETTLE_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   gen_ready,
    input  logic [31:0]            gen_num,
    output logic                   gen_trig,
    input  logic [31:0]            cfg_bound,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_data,
    output logic [$clog2(DEPTH):0] level,
    output logic [15:0]            reject_cnt
);

    localparam int unsigned LW          = $clog2(DEPTH) + 1;
    localparam int unsigned CW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int unsigned SMEAR_STEPS = $clog2(DATA_W);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE - 1);
    localparam logic [LW-1:0] FULL_LVL    = LW'(DEPTH);

    fetch_state_e      state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [REJ_W-1:0]  rej_q, rej_d;
    logic [DATA_W-1:0] mask;
    sample_t           smp;
    logic              sample_en;
    logic              push;
    logic              reject;
    logic              pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_WAIT_GEN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Losing gen_ready always restarts the settle sequence from WAIT_GEN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!gen_ready) begin
            state_d = ST_WAIT_GEN;
        end else begin
            case (state_q)
                ST_WAIT_GEN: begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETTLE_LOAD;
                end
                ST_SETTLE: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CW'(1);
                    end else if (level < FULL_LVL) begin
                        state_d = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETTLE_LOAD;
                end
                default: state_d = ST_WAIT_GEN;
            endcase
        end
    end

    always_comb begin
        gen_trig  = 1'b0;
        sample_en = 1'b0;
        if ((state_q == ST_FETCH) && gen_ready) begin
            gen_trig  = 1'b1;
            sample_en = 1'b1;
        end
    end

    // Smear bound-1 rightwards to get the smallest all-ones mask covering it.
    always_comb begin
        mask = cfg_bound - DATA_W'(1);
        for (int unsigned i = 0; i < SMEAR_STEPS; i++) begin
            mask = mask | (mask >> (1 << i));
        end
        smp.value  = (cfg_bound == '0) ? gen_num : (gen_num & mask);
        smp.accept = (cfg_bound == '0) || (smp.value < cfg_bound);
    end

    assign push   = sample_en && smp.accept;
    assign reject = sample_en && !smp.accept;
    assign pop    = out_valid && out_ready;

    always_comb begin
        rej_d = rej_q;
        if (reject && (rej_q != '1)) begin
            rej_d = rej_q + REJ_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rej_q <= '0;
        end else begin
            rej_q <= rej_d;
        end
    end

    assign reject_cnt = rej_q;

    mt_fifo #(
        .DEPTH (DEPTH),
        .DW    (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (smp.value),
        .pop_i   (pop),
        .rdata_o (out_data),
        .valid_o (out_valid),
        .level_o (level)
    );

endmodule

// File: doc/mt_stream_buffer.md
MT_STREAM_BUFFER -- requirements
Module: mt_stream_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries; power of two, at least 2.
REQ-002 SHALL have parameter SETTLE, default 2, minimum idle cycles between generator advances.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state is updated on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port gen_ready, input, 1 bit, generator is in its extract phase.
REQ-006 SHALL have port gen_num, input, 32 bits, tempered word at the generator's current index.
REQ-007 SHALL have port gen_trig, output, 1 bit, advances the generator index by one.
REQ-008 SHALL have port cfg_bound, input, 32 bits, range bound; 0 means full 32-bit passthrough.
REQ-009 SHALL have port out_valid, output, 1 bit, a word is available at out_data.
REQ-010 SHALL have port out_ready, input, 1 bit, the consumer accepts the word.
REQ-011 SHALL have port out_data, output, 32 bits, head-of-FIFO random word.
REQ-012 SHALL have port level, output, $clog2(DEPTH)+1 bits, FIFO occupancy.
REQ-013 SHALL have port reject_cnt, output, 16 bits, saturating count of rejected samples.

Function
REQ-014 SHALL implement a fetch FSM with states WAIT_GEN, SETTLE and FETCH.
REQ-015 WAIT_GEN: on gen_ready=1, SHALL go to SETTLE and load the settle counter with SETTLE-1.
REQ-016 SETTLE: SHALL decrement the counter while it is nonzero.
REQ-017 SETTLE: when counter=0, gen_ready=1 and level<DEPTH, SHALL go to FETCH.
REQ-018 FETCH: gen_trig SHALL be 1 for exactly this one cycle, and only if gen_ready=1.
REQ-019 FETCH: gen_num SHALL be sampled in this same cycle, the FSM SHALL return to SETTLE, and the counter SHALL reload SETTLE-1.
REQ-020 In any state, gen_ready=0 SHALL force WAIT_GEN on the next cycle with gen_trig=0 and no sample; this includes FETCH.
REQ-021 Range reduction: mask = 2^k-1, the smallest such value that is >= cfg_bound-1; value = gen_num & mask.
REQ-022 If cfg_bound=0, the sample SHALL be gen_num unmodified and always accepted.
REQ-023 If cfg_bound=1, mask SHALL be 0 and every sample SHALL be accepted with value 0.
REQ-024 For cfg_bound>1, a sample SHALL be accepted if value<cfg_bound; otherwise it SHALL be rejected.
REQ-025 A rejected sample SHALL increment reject_cnt, which saturates at 0xFFFF.
REQ-026 cfg_bound SHALL be evaluated at the FETCH cycle only; words already in the FIFO SHALL NOT be altered.
REQ-027 An accepted sample SHALL be pushed in the FETCH cycle and be visible at out_valid/out_data on the next cycle; push-to-output latency is 1 cycle.
REQ-028 A pop SHALL occur when out_valid and out_ready are both 1; out_data SHALL then show the next entry on the next cycle.
REQ-029 out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-030 A simultaneous push and pop SHALL leave level unchanged.
REQ-031 A push SHALL never occur when full, guaranteed by REQ-017; a pop SHALL never occur when empty.
REQ-032 Read and write pointers SHALL wrap modulo DEPTH.
REQ-033 Maximum fetch rate SHALL be one FETCH per SETTLE+1 cycles.

Reset
REQ-034 On rst: FSM=WAIT_GEN, gen_trig=0, out_valid=0, out_data=0, level=0, reject_cnt=0, pointers=0, settle counter=0.
REQ-035 rst asserted mid-FETCH SHALL drop gen_trig immediately and discard the sample.
REQ-036 After rst deasserts, the first gen_trig SHALL be no earlier than SETTLE+1 cycles after gen_ready is seen high.

Structure
REQ-037 Package mt_pkg SHALL hold the fetch-state enum and the DEPTH and SETTLE defaults.
REQ-038 Storage, pointers and level SHALL be a sub-module mt_fifo (DEPTH x 32, single clock, 1-cycle registered head).
REQ-039 Mask generation and the accept compare SHALL be combinational inside mt_stream_buffer.

Verification
REQ-040 Bench generator model: cfg_bound=0, gen_num sequence 0x11111111, 0x22222222, 0x33333333, out_ready=1 -> out_data in that order; gen_trig pulses exactly 3 cycles apart (SETTLE=2).
REQ-041 cfg_bound=6, gen_num 5, 7, 2 -> mask 7; out_data 5 then 2; reject_cnt=1; level never exceeds 1 with out_ready=1.
REQ-042 out_ready=0, DEPTH=8 -> exactly 8 gen_trig pulses, level=8, gen_trig stays 0; one pop -> a 9th trig follows within SETTLE+1 cycles.
REQ-043 gen_ready drops in the FETCH cycle -> gen_trig=0, no push, FSM=WAIT_GEN; on gen_ready rising, the first trig comes SETTLE+1 cycles later.
REQ-044 rst pulsed with level=5 and reject_cnt=3 -> all outputs 0 in the same cycle, asynchronously.
REQ-045 cfg_bound=1, any gen_num -> out_data=0 for every word, reject_cnt stays 0.
